// File: rtl/phase_pkg.sv
// Shared constants for the 603 instruction phase sequencer.
// State codes, execute-unit bit positions and counter width.
package phase_pkg;

  typedef logic [2:0] state_t;

  localparam state_t FE  = 3'd0;
  localparam state_t DE2 = 3'd1;
  localparam state_t EX  = 3'd3;
  localparam state_t EXW = 3'd7;
  localparam state_t MEM = 3'd2;

  localparam int U_BIT   = 0;
  localparam int U_SHIFT = 1;
  localparam int U_MULT  = 2;
  localparam int U_DIV   = 3;
  localparam int U_ADD   = 4;

  localparam logic [4:0] DEF_MULTI_MASK = 5'b01100;

  localparam int CNT_W = 10;

endpackage

// File: rtl/phase_cnt.sv
// Loadable down counter shared by the MEM latency
// and the EXW watchdog; load wins over decrement.
module phase_cnt
  import phase_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] loadVal,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // load, decrement or hold the remaining cycle count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle instruction phase sequencer for the 603 core.
// FE -> DE2 -> EX -> (EXW | MEM) -> FE, strobes decoded from state.
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int                   NUM_UNITS  = 5,
  parameter logic [NUM_UNITS-1:0] MULTI_MASK = DEF_MULTI_MASK,
  parameter int                   MEM_LAT    = 1,
  parameter int                   EX_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_vld,
  input  logic                 rs2_en,
  input  logic [NUM_UNITS-1:0] unit_en,
  input  logic [NUM_UNITS-1:0] unit_sub,
  input  logic                 mem_en,
  input  logic                 store_en,
  input  logic                 ex_done,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 gate_en,
  output logic                 clk_fe_en,
  output logic                 clk_mem_en,
  output logic                 ctrl_rf,
  output logic [NUM_UNITS-1:0] ctrl_de2,
  output logic [NUM_UNITS-1:0] ctrl_ex,
  output logic                 ctrl_mem_rd,
  output logic                 ctrl_wb,
  output logic [NUM_UNITS-1:0] ex_iso,
  output logic                 wb_iso,
  output logic                 ex_timeout,
  output logic [2:0]           state_o
);

  localparam logic [CNT_W-1:0] EXW_LOAD = CNT_W'(EX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LAT - 1);

  state_t           state;
  state_t           nextState;
  logic             cntLoad;
  logic             cntDec;
  logic [CNT_W-1:0] cntLoadVal;
  logic             cntZero;
  logic             wbNow;
  logic             setTimeout;
  logic             isMulti;
  logic             isLoad;

  assign isMulti = |(unit_en & MULTI_MASK);
  assign isLoad  = mem_en & ~store_en;

  phase_cnt u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cntLoad),
    .dec     (cntDec),
    .loadVal (cntLoadVal),
    .zero    (cntZero)
  );

  // next state, counter control and the final-cycle writeback
  always_comb begin
    nextState  = state;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLoadVal = '0;
    wbNow      = 1'b0;
    setTimeout = 1'b0;
    if (flush) begin
      nextState = FE;
    end else if (!stall) begin
      unique case (state)
        FE: begin
          if (fetch_vld) nextState = DE2;
        end
        DE2: begin
          nextState = EX;
        end
        EX: begin
          if (isMulti) begin
            nextState  = EXW;
            cntLoad    = 1'b1;
            cntLoadVal = EXW_LOAD;
          end else if (isLoad) begin
            nextState  = MEM;
            cntLoad    = 1'b1;
            cntLoadVal = MEM_LOAD;
          end else begin
            nextState = FE;
            wbNow     = ~mem_en;
          end
        end
        EXW: begin
          if (ex_done) begin
            nextState = FE;
            wbNow     = 1'b1;
          end else if (cntZero) begin
            nextState  = FE;
            setTimeout = 1'b1;
          end else begin
            cntDec = 1'b1;
          end
        end
        MEM: begin
          if (cntZero) begin
            nextState = FE;
            wbNow     = 1'b1;
          end else begin
            cntDec = 1'b1;
          end
        end
        default: begin
          nextState = FE;
        end
      endcase
    end
  end

  // state register and sticky watchdog flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FE;
      ex_timeout <= 1'b0;
    end else begin
      state <= nextState;
      if (setTimeout) ex_timeout <= 1'b1;
    end
  end

  // unit and memory strobes decoded from the current state
  always_comb begin
    ctrl_de2    = '0;
    ctrl_ex     = '0;
    ctrl_rf     = 1'b0;
    ctrl_mem_rd = 1'b0;
    unique case (state)
      DE2: begin
        ctrl_de2 = unit_en;
        ctrl_rf  = rs2_en;
      end
      EX: begin
        ctrl_de2 = unit_en;
        ctrl_ex  = unit_en & unit_sub;
        ctrl_rf  = rs2_en;
      end
      EXW: begin
        ctrl_ex = unit_en & unit_sub;
      end
      MEM: begin
        ctrl_ex     = unit_en & unit_sub;
        ctrl_mem_rd = ~flush;
      end
      default: begin
        ctrl_de2 = '0;
      end
    endcase
  end

  assign ctrl_wb    = wbNow;
  assign ex_iso     = ~ctrl_ex;
  assign wb_iso     = ~ctrl_wb;
  assign clk_fe_en  = (state == FE) | (nextState == FE);
  assign clk_mem_en = (state == FE) | (state == DE2);
  assign gate_en    = ~((state == FE) & (nextState == FE));
  assign state_o    = state;

endmodule
